clk_reset_gen: RTL and testbench
================================

// Module: clk_reset_gen
// PURPOSE
//   Parametrised clock-enable and reset generator for the CPU top level.
//   Produces NUM_CH independently programmable divided enables and 50%-duty toggle outputs from one clock.
//   Also produces a stretched, synchronous reset (rst_out) and a locked flag for the cores and peripherals.
//   Sits between the board clock and riscv_i / UART instances; divisors are runtime-writable.
// PARAMETERS
//   NUM_CH      2    number of divider channels (1..8)
//   DIV_W       16   divisor / counter width in bits
//   DEFAULT_DIV 15   divisor loaded at reset; period = DEFAULT_DIV+1 cycles
//   RST_HOLD    4    cycles rst_out stays high after reset is sampled low (0..255)
// PORTS
//   clk          in   1             system clock, all logic on rising edge
//   reset        in   1             synchronous, active-high reset
//   div_wr_en    in   1             divisor write strobe, one cycle
//   div_wr_ch    in   3             target channel index
//   div_wr_data  in   DIV_W         new divisor D
//   ce_out       out  NUM_CH        per-channel one-cycle clock-enable pulse
//   clk_div_out  out  NUM_CH        per-channel toggle output, period 2*(D+1)
//   rst_out      out  1             stretched synchronous reset to downstream logic
//   locked       out  1             high when rst_out low and dividers running
// BEHAVIOUR
//   Reset (reset=1, sampled at edge): counters=0, div_act=div_shd=DEFAULT_DIV, clk_div_out=0,
//     rst_out=1, locked=0, ce_out=0, hold counter=0. Applies mid-operation with same result.
//   Reset FSM: ASSERT (reset=1) -> HOLD (reset=0, hold cnt counts) -> RUN after RST_HOLD edges.
//     rst_out falls on the RST_HOLD-th edge with reset sampled low (RST_HOLD=0: first such edge).
//     reset=1 in HOLD or RUN -> ASSERT immediately, hold counter cleared.
//   locked = registered ~rst_out; falls with rst_out on reset, rises with rst_out falling.
//   Per channel i, while rst_out=1: cnt held 0, ce_out[i]=0, clk_div_out[i] held 0.
//   While rst_out=0: ce_out[i] = (cnt==div_act) decoded from registers; on that edge cnt<=0,
//     clk_div_out[i] toggles, div_act<=div_shd; otherwise cnt<=cnt+1.
//   First ce_out after rst_out falls: cycle D (0-based), i.e. D+1 cycles latency.
//   D=0: ce_out[i] constant 1, clk_div_out[i] toggles every cycle (period 2).
//   D=2^DIV_W-1: counter reaches all-ones then wraps to 0; no overflow past D possible.
//   Write: div_wr_en=1 -> div_shd[div_wr_ch]<=div_wr_data; div_act updates only at next wrap (glitch-free).
//     Write and wrap on same channel in same cycle: written value is loaded directly into div_act.
//     div_wr_ch >= NUM_CH: write ignored, no state change.
//     Write while rst_out=1 accepted; becomes active at first wrap after release.
// CONFIGURATION
//   CLKGEN_RESYNC_EN defined: adds input port resync (1 bit). resync=1 while rst_out=0 clears all
//     counters and clk_div_out to 0 and loads div_act<=div_shd on all channels that edge; ce_out
//     is 0 in the cycle after; channels become phase-aligned. resync ignored while rst_out=1;
//     reset has priority over resync.
//   Undefined: resync port absent; channels only realign via reset.
// TESTING
//   reset=1 for 3 cycles then 0, RST_HOLD=4 -> rst_out low exactly 4 edges later, locked rises same edge.
//   Defaults, after release -> ce_out[0] pulses every 16 cycles, first at cycle 15; clk_div_out[0] period 32.
//   Write ch1 D=3 mid-period -> old period (16) completes, then ce_out[1] every 4 cycles; ch0 unaffected.
//   Write D=0 to ch0 -> after next wrap ce_out[0] stuck 1, clk_div_out[0] toggles every cycle;
//     write ch=5 (NUM_CH=2) -> no channel changes.
//   reset=1 mid-run for 1 cycle -> rst_out=1, all outputs zero, divisors back to 15 next edge.
//   CLKGEN_RESYNC_EN, ch0 D=3, ch1 D=7, pulse resync -> both cnt=0 and ce_out[1] coincides with every 2nd ce_out[0].

Source files
------------

// File: rtl/clk_reset_gen.sv
// Clock-enable / toggle divider bank with a stretched synchronous reset and locked flag.
// Optional build macro CLKGEN_RESYNC_EN adds a resync input that phase-aligns all channels.
module clk_reset_gen #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 15,
   parameter int RST_HOLD    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              div_wr_en,
   input  logic [2:0]        div_wr_ch,
   input  logic [DIV_W-1:0]  div_wr_data,
`ifdef CLKGEN_RESYNC_EN
   input  logic              resync,
`endif
   output logic [NUM_CH-1:0] ce_out,
   output logic [NUM_CH-1:0] clk_div_out,
   output logic              rst_out,
   output logic              locked
);

   localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
   localparam logic [7:0]       HOLD_LIM = 8'(RST_HOLD);

   typedef enum logic [1:0] {
      S_ASSERT,
      S_HOLD,
      S_RUN
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_hold_cnt;
   logic [7:0] w_hold_nxt;
   logic [7:0] w_hold_inc;
   logic       r_rst_out;
   logic       w_rst_nxt;
   logic       r_locked;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_ASSERT;
         r_hold_cnt <= '0;
         r_rst_out  <= 1'b1;
         r_locked   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_rst_out  <= w_rst_nxt;
         r_locked   <= ~w_rst_nxt;
      end
   end

   // Counts edges with reset low; RST_HOLD of 0 or 1 both release on the first such edge.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_rst_nxt   = r_rst_out;
      w_hold_inc  = r_hold_cnt + 8'd1;
      case (r_state)
         S_ASSERT, S_HOLD: begin
            w_hold_nxt = w_hold_inc;
            if (w_hold_inc >= HOLD_LIM) begin
               w_state_nxt = S_RUN;
               w_rst_nxt   = 1'b0;
            end else begin
               w_state_nxt = S_HOLD;
               w_rst_nxt   = 1'b1;
            end
         end
         S_RUN: begin
            w_rst_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = S_ASSERT;
            w_rst_nxt   = 1'b1;
         end
      endcase
   end

   assign rst_out = r_rst_out;
   assign locked  = r_locked;

   logic w_resync;
   logic r_resync_d;

`ifdef CLKGEN_RESYNC_EN
   assign w_resync = resync & ~r_rst_out;

   // Suppresses ce_out in the cycle following a resync, even for D=0 channels.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resync_d <= 1'b0;
      end else begin
         r_resync_d <= w_resync;
      end
   end
`else
   assign w_resync   = 1'b0;
   assign r_resync_d = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] r_cnt;
      logic [DIV_W-1:0] r_div_act;
      logic [DIV_W-1:0] r_div_shd;
      logic             r_clk_div;
      logic             w_wr_hit;
      logic             w_wrap;
      logic [DIV_W-1:0] w_shd_nxt;

      assign w_wr_hit  = div_wr_en && (div_wr_ch == 3'(i));
      assign w_wrap    = (r_cnt == r_div_act);
      // A write landing on the wrap edge goes straight into the active divisor.
      assign w_shd_nxt = w_wr_hit ? div_wr_data : r_div_shd;

      assign ce_out[i]      = ~r_rst_out & ~r_resync_d & w_wrap;
      assign clk_div_out[i] = r_clk_div;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_cnt     <= '0;
            r_div_act <= DEF_DIV;
            r_div_shd <= DEF_DIV;
            r_clk_div <= 1'b0;
         end else begin
            r_div_shd <= w_shd_nxt;
            if (r_rst_out) begin
               r_cnt     <= '0;
               r_clk_div <= 1'b0;
            end else if (w_resync) begin
               r_cnt     <= '0;
               r_clk_div <= 1'b0;
               r_div_act <= w_shd_nxt;
            end else if (w_wrap) begin
               r_cnt     <= '0;
               r_clk_div <= ~r_clk_div;
               r_div_act <= w_shd_nxt;
            end else begin
               r_cnt <= r_cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_reset_gen.sv
// Directed bench for clk_reset_gen (NUM_CH=2, DIV_W=16, DEFAULT_DIV=15, RST_HOLD=4).
// Resync vectors are included when CLKGEN_RESYNC_EN is defined.
module tb_clk_reset_gen;

   localparam int NUM_CH = 2;
   localparam int DIV_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              div_wr_en;
   logic [2:0]        div_wr_ch;
   logic [DIV_W-1:0]  div_wr_data;
   logic [NUM_CH-1:0] ce_out;
   logic [NUM_CH-1:0] clk_div_out;
   logic              rst_out;
   logic              locked;
`ifdef CLKGEN_RESYNC_EN
   logic              resync;
`endif

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic e0;
   logic e1;

   always #5 clk = ~clk;

   clk_reset_gen #(
      .NUM_CH(NUM_CH),
      .DIV_W(DIV_W),
      .DEFAULT_DIV(15),
      .RST_HOLD(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .div_wr_en(div_wr_en),
      .div_wr_ch(div_wr_ch),
      .div_wr_data(div_wr_data),
`ifdef CLKGEN_RESYNC_EN
      .resync(resync),
`endif
      .ce_out(ce_out),
      .clk_div_out(clk_div_out),
      .rst_out(rst_out),
      .locked(locked)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_wr(input logic [2:0] ch, input logic [DIV_W-1:0] d);
      div_wr_en   = 1'b1;
      div_wr_ch   = ch;
      div_wr_data = d;
   endtask

   initial begin
      reset       = 1'b1;
      div_wr_en   = 1'b0;
      div_wr_ch   = '0;
      div_wr_data = '0;
`ifdef CLKGEN_RESYNC_EN
      resync      = 1'b0;
`endif

      repeat (3) step();
      check_val("rst_out_in_reset", rst_out, 1'b1);
      check_val("locked_in_reset", locked, 1'b0);
      check_val("ce_in_reset", ce_out, 2'b00);
      check_val("clkdiv_in_reset", clk_div_out, 2'b00);

      // Release: rst_out falls on the 4th edge with reset low, locked rises with it.
      reset = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         check_val("rst_out_hold", rst_out, (e < 4));
         check_val("locked_hold", locked, (e == 4));
      end

      // Defaults, ch1 rewritten to 3 mid-period, ch0 to 0, out-of-range write.
      cyc = 0;
      for (int n = 0; n < 120; n++) begin
         e0 = (cyc < 112) ? (cyc % 16 == 15) : 1'b1;
         e1 = (cyc < 64) ? (cyc % 16 == 15) : ((cyc - 64) % 4 == 3);
         check_val("ce0_run", ce_out[0], e0);
         check_val("ce1_run", ce_out[1], e1);
         if (cyc < 48)   check_val("clk0_period32", clk_div_out[0], (cyc / 16) % 2);
         if (cyc >= 112) check_val("clk0_d0_toggle", clk_div_out[0], (cyc - 111) % 2);
         if (cyc == 64)  check_val("clk1_after_switch", clk_div_out[1], 1'b0);
         if (cyc == 70)  check_val("clk1_d3_toggle", clk_div_out[1], 1'b1);
         if (cyc == 53)  drive_wr(3'd1, 16'd3);
         if (cyc == 100) drive_wr(3'd0, 16'd0);
         if (cyc == 101) drive_wr(3'd5, 16'd7);
         step();
         div_wr_en = 1'b0;
      end

      // One-cycle reset mid-run.
      reset = 1'b1;
      step();
      check_val("rst_out_midrun", rst_out, 1'b1);
      check_val("locked_midrun", locked, 1'b0);
      check_val("ce_midrun", ce_out, 2'b00);
      check_val("clkdiv_midrun", clk_div_out, 2'b00);
      reset = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         if (e == 2) drive_wr(3'd1, 16'd1);
         step();
         div_wr_en = 1'b0;
         check_val("rst_out_rehold", rst_out, (e < 4));
      end

      // Divisors back at 15; ch1 write during hold takes effect at first wrap;
      // ch0 write on its wrap edge loads directly.
      cyc = 0;
      for (int n = 0; n < 45; n++) begin
         e0 = (cyc < 32) ? (cyc % 16 == 15) : ((cyc - 32) % 6 == 5);
         e1 = (cyc < 16) ? (cyc == 15) : ((cyc - 16) % 2 == 1);
         check_val("ce0_after_reset", ce_out[0], e0);
         check_val("ce1_after_reset", ce_out[1], e1);
         if (cyc == 31) drive_wr(3'd0, 16'd5);
         step();
         div_wr_en = 1'b0;
      end

`ifdef CLKGEN_RESYNC_EN
      drive_wr(3'd0, 16'd3);
      step();
      drive_wr(3'd1, 16'd7);
      step();
      div_wr_en = 1'b0;
      resync    = 1'b1;
      step();
      resync    = 1'b0;
      cyc = 0;
      check_val("clkdiv_after_resync", clk_div_out, 2'b00);
      for (int n = 0; n < 24; n++) begin
         check_val("ce0_resync", ce_out[0], (cyc % 4 == 3));
         check_val("ce1_resync", ce_out[1], (cyc % 8 == 7));
         step();
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
